// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the word-wide, byte-addressed data-RAM port.
//               Performs RV32I loads with extension, and byte/half stores as a
//               read-modify-write. Rejects protected/out-of-range accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int unsigned PROT_LIMIT       = 23,
    parameter int unsigned MEM_BYTES        = 64,
    parameter bit          MISALIGNED_FAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        ram_read_en,
    output logic        ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    localparam logic [32:0] c_mem_end = 33'(MEM_BYTES);

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;

    logic [2:0]  w_size;
    logic [32:0] w_end;
    logic        w_bad_f3;
    logic        w_misaligned;
    logic        w_fault;
    logic        w_is_sw;
    logic [31:0] w_load;
    logic [31:0] w_store_word;

    // Access checks on the live request. The 33-bit end address cannot wrap,
    // so addresses near 0xFFFFFFFF land in the out-of-range term.
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   w_size = 3'd2;
            2'b10:   w_size = 3'd4;
            default: w_size = 3'd1;
        endcase
        w_end = {1'b0, req_addr} + {30'd0, w_size};

        if (req_we) begin
            w_bad_f3 = (req_funct3 != c_f3_b) && (req_funct3 != c_f3_h) &&
                       (req_funct3 != c_f3_w);
        end else begin
            w_bad_f3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111);
        end

        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        w_fault = (req_addr <= PROT_LIMIT) || (w_end > c_mem_end) || w_bad_f3 ||
                  (MISALIGNED_FAULT && w_misaligned);

        w_is_sw = req_we && (req_funct3 == c_f3_w);
    end

    // The addressed byte is lane 0 of the RAM word, so extension works in place.
    always_comb begin
        case (r_funct3)
            c_f3_b:  w_load = {{24{ram_read_data[7]}}, ram_read_data[7:0]};
            c_f3_h:  w_load = {{16{ram_read_data[15]}}, ram_read_data[15:0]};
            c_f3_bu: w_load = {24'd0, ram_read_data[7:0]};
            c_f3_hu: w_load = {16'd0, ram_read_data[15:0]};
            default: w_load = ram_read_data;
        endcase
    end

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_store_word = {r_word[31:8], r_wdata[7:0]};
            2'b01:   w_store_word = {r_word[31:16], r_wdata[15:0]};
            default: w_store_word = r_wdata;
        endcase
    end

    assign ram_addr       = r_addr;
    assign ram_write_data = ram_write_en ? w_store_word : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_word       <= 32'd0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_fault   <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (w_fault) begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (w_is_sw) begin
                            r_state      <= S_WRITE;
                            ram_write_en <= 1'b1;
                        end else begin
                            r_state     <= S_READ;
                            ram_read_en <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_word      <= ram_read_data;
                    ram_read_en <= 1'b0;
                    if (r_we) begin
                        r_state      <= S_WRITE;
                        ram_write_en <= 1'b1;
                    end else begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= w_load;
                    end
                end
                S_WRITE: begin
                    ram_write_en <= 1'b0;
                    r_state      <= S_RESP;
                    resp_valid   <= 1'b1;
                    resp_fault   <= 1'b0;
                    resp_rdata   <= 32'd0;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               64-byte RAM model; a second instance covers misalignment faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_valid1, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_fault, ram_read_en, ram_write_en;
    logic [31:0] resp_rdata, ram_addr, ram_write_data, ram_read_data;
    logic        req_ready1, resp_valid1, resp_fault1, ram_read_en1, ram_write_en1;
    logic [31:0] resp_rdata1, ram_addr1, ram_write_data1, ram_read_data1;

    logic [7:0]  mem [0:63];
    int          nwrites = 0;
    int          nresp   = 0;
    logic [31:0] last_wdata;
    int          checks  = 0;
    int          fails   = 0;
    int          w0, r0, lat;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    load_store_unit #(.MISALIGNED_FAULT(1'b1)) dut_mis (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
        .resp_fault(resp_fault1), .ram_read_en(ram_read_en1), .ram_write_en(ram_write_en1),
        .ram_addr(ram_addr1), .ram_write_data(ram_write_data1), .ram_read_data(ram_read_data1)
    );

    always_comb begin
        ram_read_data  = 32'd0;
        ram_read_data1 = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if ({1'b0, ram_addr} + 33'(i) < 33'd64)
                ram_read_data[8*i +: 8] = mem[ram_addr[5:0] + 6'(i)];
            if ({1'b0, ram_addr1} + 33'(i) < 33'd64)
                ram_read_data1[8*i +: 8] = mem[ram_addr1[5:0] + 6'(i)];
        end
    end

    // Only the default-parameter instance commits to the RAM model.
    always @(posedge clk) begin
        if (resp_valid) nresp++;
        if (ram_write_en) begin
            nwrites++;
            last_wdata = ram_write_data;
            for (int i = 0; i < 4; i++)
                if ({1'b0, ram_addr} + 33'(i) < 33'd64)
                    mem[ram_addr[5:0] + 6'(i)] = ram_write_data[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and measure cycles from the accept edge to resp_valid.
    task automatic run(input string tag, input bit sel, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_fault);
        int guard = 0;
        int l;
        @(negedge clk);
        while (!(sel ? req_ready1 : req_ready) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (sel) req_valid1 = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_valid1 = 1'b0;
        l = 1;
        while (!(sel ? resp_valid1 : resp_valid) && l < 10) begin
            @(posedge clk);
            #1;
            l++;
        end
        chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
        chk({tag, "_rdata"}, sel ? resp_rdata1 : resp_rdata, exp_rdata);
        chk({tag, "_fault"}, 32'(sel ? resp_fault1 : resp_fault), 32'(exp_fault));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = 0; req_valid1 = 0; req_we = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[24] = 8'h11; mem[25] = 8'h22; mem[26] = 8'h33; mem[27] = 8'h44;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_fault", 32'(resp_fault), 32'd0);
        chk("rst_rd_en", 32'(ram_read_en), 32'd0);
        chk("rst_wr_en", 32'(ram_write_en), 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_wdata", ram_write_data, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("lw24", 0, 0, 3'b010, 32'd24, 0, 2, 32'h44332211, 0);
        chk("lw24_nowrite", 32'(nwrites), 32'd0);

        mem[24] = 8'h01; mem[25] = 8'h80;
        run("lb25", 0, 0, 3'b000, 32'd25, 0, 2, 32'hFFFFFF80, 0);
        run("lbu25", 0, 0, 3'b100, 32'd25, 0, 2, 32'h00000080, 0);
        run("lh24", 0, 0, 3'b001, 32'd24, 0, 2, 32'hFFFF8001, 0);
        run("lhu24", 0, 0, 3'b101, 32'd24, 0, 2, 32'h00008001, 0);
        mem[24] = 8'h11; mem[25] = 8'h22;

        w0 = nwrites;
        run("sb26", 0, 1, 3'b000, 32'd26, 32'h123456AB, 3, 32'd0, 0);
        chk("sb26_nwrites", 32'(nwrites), 32'(w0 + 1));
        chk("sb26_word", last_wdata, 32'h000044AB);
        chk("sb26_m26", 32'(mem[26]), 32'h000000AB);
        chk("sb26_m27", 32'(mem[27]), 32'h00000044);
        run("lw24_after_sb", 0, 0, 3'b010, 32'd24, 0, 2, 32'h44AB2211, 0);

        run("sw40", 0, 1, 3'b010, 32'd40, 32'hDEADBEEF, 2, 32'd0, 0);
        run("sh40", 0, 1, 3'b001, 32'd40, 32'hFFFF1234, 3, 32'd0, 0);
        run("lw40", 0, 0, 3'b010, 32'd40, 0, 2, 32'hDEAD1234, 0);

        w0 = nwrites;
        run("sw8_prot", 0, 1, 3'b010, 32'd8, 32'hCAFEF00D, 1, 32'd0, 1);
        chk("sw8_nowrite", 32'(nwrites), 32'(w0));
        run("lw62_range", 0, 0, 3'b010, 32'd62, 0, 1, 32'd0, 1);
        mem[63] = 8'h5A;
        run("lb63_edge", 0, 0, 3'b000, 32'd63, 0, 2, 32'h0000005A, 0);
        run("lw60_edge", 0, 0, 3'b010, 32'd60, 0, 2, 32'h5A000000, 0);
        run("lb23_prot", 0, 0, 3'b000, 32'd23, 0, 1, 32'd0, 1);
        run("lb_wrap", 0, 0, 3'b000, 32'hFFFFFFFE, 0, 1, 32'd0, 1);

        run("ld_f3_011", 0, 0, 3'b011, 32'd24, 0, 1, 32'd0, 1);
        run("st_f3_100", 0, 1, 3'b100, 32'd40, 32'h1, 1, 32'd0, 1);
        run("lh25_allow", 0, 0, 3'b001, 32'd25, 0, 2, 32'hFFFFAB22, 0);
        run("lh25_mis", 1, 0, 3'b001, 32'd25, 0, 1, 32'd0, 1);
        run("lw24_mis_ok", 1, 0, 3'b010, 32'd24, 0, 2, 32'h44AB2211, 0);

        // A second request presented while the unit is in READ must be dropped.
        @(negedge clk);
        req_we = 0; req_funct3 = 3'b010; req_addr = 32'd24; req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_ready", 32'(req_ready), 32'd0);
        chk("busy_rd_en", 32'(ram_read_en), 32'd1);
        w0 = nwrites;
        req_we = 1; req_funct3 = 3'b010; req_addr = 32'd40; req_wdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_resp", 32'(resp_valid), 32'd1);
        chk("busy_rdata", resp_rdata, 32'h44AB2211);
        r0 = nresp;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_ignored_wr", 32'(nwrites), 32'(w0));
        chk("busy_ignored_resp", 32'(nresp), 32'(r0 + 1));

        // Reset while an SH sits in WRITE.
        @(negedge clk);
        req_we = 1; req_funct3 = 3'b001; req_addr = 32'd24; req_wdata = 32'h0000BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_in_write", 32'(ram_write_en), 32'd1);
        w0 = nwrites;
        r0 = nresp;
        rst = 1'b1;
        #1;
        chk("rstw_wr_en", 32'(ram_write_en), 32'd0);
        chk("rstw_ready", 32'(req_ready), 32'd1);
        chk("rstw_resp", 32'(resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstw_nowrite", 32'(nwrites), 32'(w0));
        chk("rstw_m24", 32'(mem[24]), 32'h00000011);
        chk("rstw_m25", 32'(mem[25]), 32'h00000022);
        chk("rstw_noresp", 32'(nresp), 32'(r0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
